flight_seq: RTL

Flight sequencer that sits in front of `dronetop` and owns the arm, spin-up, fly, land and fault life-cycle. It accepts host flight commands over a valid/ready handshake. It drives `altcmd`/`dircmd` into `dronetop` and gates the motor drivers through `mot_en`. It also supervises the four sensed motor RPMs for spin-up failure and in-flight stalls, and lands automatically on host command timeout.

---
 rtl/drone_pkg.sv | 24 ++
 rtl/flight_seq_cycle_timer.sv | 23 ++
 rtl/flight_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/drone_pkg.sv
// Shared types and constants for the flight sequencer and its drone-side consumers.
package drone_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SPINUP = 3'd1,
      FLY    = 3'd2,
      LAND   = 3'd3,
      FAULT  = 3'd4
   } fs_state_t;

   typedef logic signed [15:0] rpm_t;

   localparam logic [2:0] ALT_HOLD    = 3'b000;
   localparam logic [2:0] ALT_UP      = 3'b001;
   localparam logic [2:0] ALT_DOWN    = 3'b010;
   localparam logic [2:0] DIR_NEUTRAL = 3'b000;

   localparam int unsigned MOT_L  = 0;
   localparam int unsigned MOT_RT = 1;
   localparam int unsigned MOT_F  = 2;
   localparam int unsigned MOT_RV = 3;

endpackage

// File: rtl/flight_seq_cycle_timer.sv
// Loadable 32-bit down-counter; done is high whenever the count has run out to zero.
module cycle_timer (
   input  logic        clk,
   input  logic        resetn,
   input  logic        load,
   input  logic [31:0] val,
   output logic        done
);

   logic [31:0] count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         count <= '0;
      else if (load)
         count <= val;
      else if (count != '0)
         count <= count - 32'd1;
   end

   assign done = (count == '0);

endmodule

// File: rtl/flight_seq.sv
// Arm / spin-up / fly / land / fault life-cycle sequencer in front of dronetop,
// with RPM supervision and automatic landing on host command timeout.
module flight_seq
   import drone_pkg::*;
#(
   parameter int unsigned SPINUP_CYC  = 1000,
   parameter int unsigned LAND_CYC    = 2000,
   parameter int unsigned CMD_TIMEOUT = 50000,
   parameter int unsigned STALL_CYC   = 16,
   parameter rpm_t        MIN_RPM     = 16'sd200
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            arm_req,
   input  logic            disarm_req,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [2:0]      host_alt,
   input  logic [1:0][2:0] host_dir,
   input  rpm_t [3:0]      rpm_sense,
   output logic [2:0]      altcmd,
   output logic [1:0][2:0] dircmd,
   output logic            mot_en,
   output logic            armed,
   output logic            fault,
   output fs_state_t       state
);

   if (SPINUP_CYC < 1 || LAND_CYC < 1 || CMD_TIMEOUT < 1 || STALL_CYC < 1 || MIN_RPM < 1) begin : g_param_chk
      $error("flight_seq: every parameter must be >= 1");
   end

   logic        any_low, accept, stall_trip, fly_land;
   logic        dwell_load, dwell_done, tmo_load, tmo_done;
   logic [31:0] dwell_val, stall_cnt;

   always_comb begin
      any_low = 1'b0;
      for (int unsigned i = 0; i < 4; i++)
         if (rpm_sense[i] < MIN_RPM) any_low = 1'b1;
   end

   assign cmd_ready  = (state == FLY) && !disarm_req;
   assign accept     = cmd_valid && cmd_ready;
   assign stall_trip = any_low && (stall_cnt >= STALL_CYC - 32'd1);
   assign fly_land   = !stall_trip && (disarm_req || tmo_done);

   // Timers are loaded with N-1 so the transition lands on exactly the N-th edge.
   always_comb begin
      dwell_load = 1'b0;
      dwell_val  = SPINUP_CYC - 32'd1;
      if (state == IDLE && arm_req) begin
         dwell_load = 1'b1;
      end else if (state == FLY && fly_land) begin
         dwell_load = 1'b1;
         dwell_val  = LAND_CYC - 32'd1;
      end
   end

   assign tmo_load = (state == SPINUP && dwell_done && !any_low) || accept;

   cycle_timer u_dwell (
      .clk    (clk),
      .resetn (resetn),
      .load   (dwell_load),
      .val    (dwell_val),
      .done   (dwell_done)
   );

   cycle_timer u_timeout (
      .clk    (clk),
      .resetn (resetn),
      .load   (tmo_load),
      .val    (CMD_TIMEOUT - 32'd1),
      .done   (tmo_done)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         altcmd    <= ALT_HOLD;
         dircmd    <= {DIR_NEUTRAL, DIR_NEUTRAL};
         mot_en    <= 1'b0;
         armed     <= 1'b0;
         fault     <= 1'b0;
         stall_cnt <= '0;
      end else begin
         case (state)
            IDLE: if (arm_req) begin
               state  <= SPINUP;
               altcmd <= ALT_UP;
               mot_en <= 1'b1;
               armed  <= 1'b1;
            end
            SPINUP: if (dwell_done) begin
               stall_cnt <= '0;
               altcmd    <= ALT_HOLD;
               if (!any_low) begin
                  state <= FLY;
               end else begin
                  state  <= FAULT;
                  mot_en <= 1'b0;
                  armed  <= 1'b0;
                  fault  <= 1'b1;
               end
            end
            FLY: begin
               stall_cnt <= any_low ? stall_cnt + 32'd1 : '0;
               if (stall_trip) begin
                  state     <= FAULT;
                  altcmd    <= ALT_HOLD;
                  dircmd    <= {DIR_NEUTRAL, DIR_NEUTRAL};
                  mot_en    <= 1'b0;
                  armed     <= 1'b0;
                  fault     <= 1'b1;
                  stall_cnt <= '0;
               end else if (fly_land) begin
                  state     <= LAND;
                  altcmd    <= ALT_DOWN;
                  dircmd    <= {DIR_NEUTRAL, DIR_NEUTRAL};
                  stall_cnt <= '0;
               end else if (accept) begin
                  altcmd <= host_alt;
                  dircmd <= host_dir;
               end
            end
            LAND: if (dwell_done) begin
               state  <= IDLE;
               altcmd <= ALT_HOLD;
               mot_en <= 1'b0;
               armed  <= 1'b0;
            end
            FAULT: if (disarm_req) begin
               state <= IDLE;
               fault <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
